// File: rtl/role_axi_pr_decoupler.sv
// AXI-MM isolation stage between the static master and a reconfigurable role.
// PASS forwards everything; DRAIN blocks new addresses and waits for in-flight
// bursts (bounded by DRAIN_TIMEOUT); DECOUPLED cuts the role off and answers
// static-side requests with SLVERR from a small responder.
// Optional: define ROLE_DECOUPLE_STATS_EN to add ERR_RESP_COUNT/TIMEOUT_COUNT.
module role_axi_pr_decoupler #(
  parameter int ID_W            = 4,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 32,
  parameter int DRAIN_TIMEOUT   = 4096,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int SW = DATA_W / 8
) (
  input  logic              CLK_IN,
  input  logic              AXI_RESET_N,
  input  logic              DECOUPLE_REQ,
  output logic              DECOUPLE_ACK,
  output logic              DRAIN_TIMEOUT_ERR,
  output logic [CW-1:0]     RD_OUTSTANDING,
  output logic [CW-1:0]     WR_OUTSTANDING,
  // static side
  input  logic [ID_W-1:0]   S_AXI_AWID,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [7:0]        S_AXI_AWLEN,
  input  logic [2:0]        S_AXI_AWSIZE,
  input  logic [1:0]        S_AXI_AWBURST,
  input  logic              S_AXI_AWLOCK,
  input  logic [3:0]        S_AXI_AWCACHE,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic [3:0]        S_AXI_AWQOS,
  input  logic [3:0]        S_AXI_AWREGION,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [DATA_W-1:0] S_AXI_WDATA,
  input  logic [SW-1:0]     S_AXI_WSTRB,
  input  logic              S_AXI_WLAST,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [ID_W-1:0]   S_AXI_BID,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ID_W-1:0]   S_AXI_ARID,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [7:0]        S_AXI_ARLEN,
  input  logic [2:0]        S_AXI_ARSIZE,
  input  logic [1:0]        S_AXI_ARBURST,
  input  logic              S_AXI_ARLOCK,
  input  logic [3:0]        S_AXI_ARCACHE,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic [3:0]        S_AXI_ARQOS,
  input  logic [3:0]        S_AXI_ARREGION,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [ID_W-1:0]   S_AXI_RID,
  output logic [DATA_W-1:0] S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RLAST,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  // role side
  output logic [ID_W-1:0]   M_AXI_AWID,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [7:0]        M_AXI_AWLEN,
  output logic [2:0]        M_AXI_AWSIZE,
  output logic [1:0]        M_AXI_AWBURST,
  output logic              M_AXI_AWLOCK,
  output logic [3:0]        M_AXI_AWCACHE,
  output logic [2:0]        M_AXI_AWPROT,
  output logic [3:0]        M_AXI_AWQOS,
  output logic [3:0]        M_AXI_AWREGION,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [DATA_W-1:0] M_AXI_WDATA,
  output logic [SW-1:0]     M_AXI_WSTRB,
  output logic              M_AXI_WLAST,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [ID_W-1:0]   M_AXI_BID,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ID_W-1:0]   M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARLOCK,
  output logic [3:0]        M_AXI_ARCACHE,
  output logic [2:0]        M_AXI_ARPROT,
  output logic [3:0]        M_AXI_ARQOS,
  output logic [3:0]        M_AXI_ARREGION,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [ID_W-1:0]   M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
`ifdef ROLE_DECOUPLE_STATS_EN
  ,
  output logic [31:0]       ERR_RESP_COUNT,
  output logic [15:0]       TIMEOUT_COUNT
`endif
);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {ST_PASS, ST_DRAIN, ST_DECOUPLED} st_t;
  typedef enum logic [1:0] {RS_IDLE, RS_WDATA, RS_BRESP, RS_RDATA} rs_t;

  st_t             st;
  rs_t             rs;
  logic [CW-1:0]   rd_cnt, wr_cnt, wb_cnt, rd_nxt, wr_nxt, wb_nxt;
  logic [TW-1:0]   tcnt;
  logic [ID_W-1:0] rs_id;
  logic [7:0]      rs_len, rs_beat;
  logic            ack_q, err_q;

  logic pass_st, drain_st, dec_st, ar_open, aw_open, w_open, rb_open, rs_idle, rs_take;
  logic ar_hs, aw_hs, wl_hs, rl_hs, b_hs, all_zero, timeout_hit;

  assign pass_st  = (st == ST_PASS);
  assign drain_st = (st == ST_DRAIN);
  assign dec_st   = (st == ST_DECOUPLED);
  assign ar_open  = pass_st && (rd_cnt != CMAX);
  assign aw_open  = pass_st && (wr_cnt != CMAX);
  // W beats owed to already-accepted AWs may still flow while draining
  assign w_open   = pass_st || (drain_st && wb_cnt != '0);
  assign rb_open  = pass_st || drain_st;
  assign rs_idle  = (rs == RS_IDLE);
  // responder only takes new work while isolation is still requested,
  // so an address arriving during the exit cycle goes to the role instead
  assign rs_take  = dec_st && rs_idle && DECOUPLE_REQ;

  assign DECOUPLE_ACK      = ack_q;
  assign DRAIN_TIMEOUT_ERR = err_q;
  assign RD_OUTSTANDING    = rd_cnt;
  assign WR_OUTSTANDING    = wr_cnt;

  assign {M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
          M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWREGION} =
         {S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
          S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION};
  assign {M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
          M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARREGION} =
         {S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
          S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION};
  assign {M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST} = {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST};

  // channel gating and response muxing; reset forces every valid/ready low
  always_comb begin
    M_AXI_ARVALID = AXI_RESET_N && ar_open && S_AXI_ARVALID;
    S_AXI_ARREADY = AXI_RESET_N && ((ar_open && M_AXI_ARREADY) || rs_take);
    M_AXI_AWVALID = AXI_RESET_N && aw_open && S_AXI_AWVALID;
    S_AXI_AWREADY = AXI_RESET_N && ((aw_open && M_AXI_AWREADY) || (rs_take && !S_AXI_ARVALID));
    M_AXI_WVALID  = AXI_RESET_N && w_open && S_AXI_WVALID;
    S_AXI_WREADY  = AXI_RESET_N && ((w_open && M_AXI_WREADY) || (rs == RS_WDATA));
    M_AXI_BREADY  = AXI_RESET_N && rb_open && S_AXI_BREADY;
    M_AXI_RREADY  = AXI_RESET_N && rb_open && S_AXI_RREADY;
    S_AXI_BVALID  = AXI_RESET_N && (rb_open ? M_AXI_BVALID : (rs == RS_BRESP));
    S_AXI_RVALID  = AXI_RESET_N && (rb_open ? M_AXI_RVALID : (rs == RS_RDATA));
    S_AXI_BID     = rb_open ? M_AXI_BID   : rs_id;
    S_AXI_BRESP   = rb_open ? M_AXI_BRESP : 2'b10;
    S_AXI_RID     = rb_open ? M_AXI_RID   : rs_id;
    S_AXI_RDATA   = rb_open ? M_AXI_RDATA : '0;
    S_AXI_RRESP   = rb_open ? M_AXI_RRESP : 2'b10;
    S_AXI_RLAST   = rb_open ? M_AXI_RLAST : (rs_beat == rs_len);
  end

  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign wl_hs = M_AXI_WVALID && M_AXI_WREADY && S_AXI_WLAST;
  assign rl_hs = M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST;
  assign b_hs  = M_AXI_BVALID && M_AXI_BREADY;

  // next outstanding counts; simultaneous +1/-1 cancel, never wrap
  always_comb begin
    rd_nxt = rd_cnt;
    wr_nxt = wr_cnt;
    wb_nxt = wb_cnt;
    if (ar_hs && !rl_hs) rd_nxt = rd_cnt + CW'(1);
    else if (!ar_hs && rl_hs && rd_cnt != '0) rd_nxt = rd_cnt - CW'(1);
    if (aw_hs && !b_hs) wr_nxt = wr_cnt + CW'(1);
    else if (!aw_hs && b_hs && wr_cnt != '0) wr_nxt = wr_cnt - CW'(1);
    if (aw_hs && !wl_hs && wb_cnt != CMAX) wb_nxt = wb_cnt + CW'(1);
    else if (!aw_hs && wl_hs && wb_cnt != '0) wb_nxt = wb_cnt - CW'(1);
  end

  assign all_zero    = (rd_nxt == '0) && (wr_nxt == '0) && (wb_nxt == '0);
  assign timeout_hit = drain_st && DECOUPLE_REQ && !all_zero && (tcnt == TW'(DRAIN_TIMEOUT - 1));

  // isolation state machine with outstanding tracking and drain timer
  always_ff @(posedge CLK_IN) begin
    if (!AXI_RESET_N) begin
      st <= ST_PASS; rd_cnt <= '0; wr_cnt <= '0; wb_cnt <= '0;
      tcnt <= '0; ack_q <= 1'b0; err_q <= 1'b0;
    end else begin
      rd_cnt <= rd_nxt; wr_cnt <= wr_nxt; wb_cnt <= wb_nxt;
      case (st)
        ST_PASS: begin
          tcnt <= '0;
          if (DECOUPLE_REQ) st <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!DECOUPLE_REQ) begin
            st <= ST_PASS; tcnt <= '0;
          end else if (all_zero) begin
            st <= ST_DECOUPLED; ack_q <= 1'b1; tcnt <= '0;
          end else if (timeout_hit) begin
            st <= ST_DECOUPLED; ack_q <= 1'b1; err_q <= 1'b1; tcnt <= '0;
            rd_cnt <= '0; wr_cnt <= '0; wb_cnt <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          if (!DECOUPLE_REQ && rs_idle) begin
            st <= ST_PASS; ack_q <= 1'b0; err_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // SLVERR responder: one transaction at a time, reads win ties
  always_ff @(posedge CLK_IN) begin
    if (!AXI_RESET_N) begin
      rs <= RS_IDLE; rs_id <= '0; rs_len <= '0; rs_beat <= '0;
    end else begin
      case (rs)
        RS_IDLE: begin
          if (rs_take && S_AXI_ARVALID) begin
            rs <= RS_RDATA; rs_id <= S_AXI_ARID; rs_len <= S_AXI_ARLEN; rs_beat <= '0;
          end else if (rs_take && S_AXI_AWVALID) begin
            rs <= RS_WDATA; rs_id <= S_AXI_AWID;
          end
        end
        RS_WDATA: if (S_AXI_WVALID && S_AXI_WLAST) rs <= RS_BRESP;
        RS_BRESP: if (S_AXI_BREADY) rs <= RS_IDLE;
        default: begin
          if (S_AXI_RREADY) begin
            if (rs_beat == rs_len) rs <= RS_IDLE;
            else rs_beat <= rs_beat + 8'd1;
          end
        end
      endcase
    end
  end

`ifdef ROLE_DECOUPLE_STATS_EN
  logic err_done;
  assign err_done = ((rs == RS_BRESP) && S_AXI_BREADY) ||
                    ((rs == RS_RDATA) && S_AXI_RREADY && rs_beat == rs_len);

  // saturating error/timeout statistics, cleared only by reset
  always_ff @(posedge CLK_IN) begin
    if (!AXI_RESET_N) begin
      ERR_RESP_COUNT <= '0; TIMEOUT_COUNT <= '0;
    end else begin
      if (err_done && ERR_RESP_COUNT != '1) ERR_RESP_COUNT <= ERR_RESP_COUNT + 32'd1;
      if (timeout_hit && TIMEOUT_COUNT != '1) TIMEOUT_COUNT <= TIMEOUT_COUNT + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_role_axi_pr_decoupler.sv
// Directed-sequence bench with random payloads for role_axi_pr_decoupler.
module tb_role_axi_pr_decoupler;
  localparam int IW = 4, AW = 32, DW = 32, SW = 4, MO = 4, TO = 16, CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, req;
  logic ack, terr;
  logic [CW-1:0] rdo, wro;
  logic [IW-1:0] s_awid, s_arid, s_bid, s_rid, m_awid, m_arid, m_bid, m_rid;
  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [7:0] s_awlen, s_arlen, m_awlen, m_arlen;
  logic [2:0] s_awsize, s_arsize, m_awsize, m_arsize, s_awprot, s_arprot, m_awprot, m_arprot;
  logic [1:0] s_awburst, s_arburst, m_awburst, m_arburst, s_bresp, s_rresp, m_bresp, m_rresp;
  logic s_awlock, s_arlock, m_awlock, m_arlock;
  logic [3:0] s_awcache, s_arcache, m_awcache, m_arcache, s_awqos, s_arqos, m_awqos, m_arqos;
  logic [3:0] s_awregion, s_arregion, m_awregion, m_arregion;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [DW-1:0] s_wdata, s_rdata, m_wdata, m_rdata;
  logic [SW-1:0] s_wstrb, m_wstrb;

  role_axi_pr_decoupler #(.ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO),
                          .DRAIN_TIMEOUT(TO)) dut (
    .CLK_IN(clk), .AXI_RESET_N(rstn), .DECOUPLE_REQ(req), .DECOUPLE_ACK(ack),
    .DRAIN_TIMEOUT_ERR(terr), .RD_OUTSTANDING(rdo), .WR_OUTSTANDING(wro),
    .S_AXI_AWID(s_awid), .S_AXI_AWADDR(s_awaddr), .S_AXI_AWLEN(s_awlen), .S_AXI_AWSIZE(s_awsize),
    .S_AXI_AWBURST(s_awburst), .S_AXI_AWLOCK(s_awlock), .S_AXI_AWCACHE(s_awcache),
    .S_AXI_AWPROT(s_awprot), .S_AXI_AWQOS(s_awqos), .S_AXI_AWREGION(s_awregion),
    .S_AXI_AWVALID(s_awvalid), .S_AXI_AWREADY(s_awready),
    .S_AXI_WDATA(s_wdata), .S_AXI_WSTRB(s_wstrb), .S_AXI_WLAST(s_wlast),
    .S_AXI_WVALID(s_wvalid), .S_AXI_WREADY(s_wready),
    .S_AXI_BID(s_bid), .S_AXI_BRESP(s_bresp), .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(s_bready),
    .S_AXI_ARID(s_arid), .S_AXI_ARADDR(s_araddr), .S_AXI_ARLEN(s_arlen), .S_AXI_ARSIZE(s_arsize),
    .S_AXI_ARBURST(s_arburst), .S_AXI_ARLOCK(s_arlock), .S_AXI_ARCACHE(s_arcache),
    .S_AXI_ARPROT(s_arprot), .S_AXI_ARQOS(s_arqos), .S_AXI_ARREGION(s_arregion),
    .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready),
    .S_AXI_RID(s_rid), .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RLAST(s_rlast),
    .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready),
    .M_AXI_AWID(m_awid), .M_AXI_AWADDR(m_awaddr), .M_AXI_AWLEN(m_awlen), .M_AXI_AWSIZE(m_awsize),
    .M_AXI_AWBURST(m_awburst), .M_AXI_AWLOCK(m_awlock), .M_AXI_AWCACHE(m_awcache),
    .M_AXI_AWPROT(m_awprot), .M_AXI_AWQOS(m_awqos), .M_AXI_AWREGION(m_awregion),
    .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WLAST(m_wlast),
    .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
    .M_AXI_BID(m_bid), .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
    .M_AXI_ARID(m_arid), .M_AXI_ARADDR(m_araddr), .M_AXI_ARLEN(m_arlen), .M_AXI_ARSIZE(m_arsize),
    .M_AXI_ARBURST(m_arburst), .M_AXI_ARLOCK(m_arlock), .M_AXI_ARCACHE(m_arcache),
    .M_AXI_ARPROT(m_arprot), .M_AXI_ARQOS(m_arqos), .M_AXI_ARREGION(m_arregion),
    .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
    .M_AXI_RID(m_rid), .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp), .M_AXI_RLAST(m_rlast),
    .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready)
  );

  logic [9:0] all_vr;
  logic [4:0] m_vr;
  assign all_vr = {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                   m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
  assign m_vr = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};

  // reference model: outstanding transactions as seen from the static side
  typedef struct { logic [IW-1:0] id; logic [7:0] len; } rd_t;
  rd_t rq[$];
  logic [IW-1:0] wq[$];

  int errs = 0, checks = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pass_ar(input logic [7:0] len);
    logic [IW-1:0] id; logic [AW-1:0] a; logic [20:0] f;
    id = IW'($urandom); a = $urandom; f = 21'($urandom);
    s_arid = id; s_araddr = a; s_arlen = len;
    {s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arqos, s_arregion} = f;
    s_arvalid = 1; m_arready = 1; #1;
    chk("ar_handshake", 64'({m_arvalid, s_arready}), 64'(2'b11));
    chk("ar_id", 64'(m_arid), 64'(id));
    chk("ar_addr", 64'(m_araddr), 64'(a));
    chk("ar_ctl", 64'({m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos,
                       m_arregion}), 64'({len, f}));
    tick();
    s_arvalid = 0; m_arready = 0;
    rq.push_back('{id, len});
    chk("rd_outstanding", 64'(rdo), 64'(rq.size()));
  endtask

  task automatic pass_aw();
    logic [IW-1:0] id; logic [AW-1:0] a; logic [20:0] f;
    id = IW'($urandom); a = $urandom; f = 21'($urandom);
    s_awid = id; s_awaddr = a; s_awlen = 8'd1;
    {s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos, s_awregion} = f;
    s_awvalid = 1; m_awready = 1; #1;
    chk("aw_handshake", 64'({m_awvalid, s_awready}), 64'(2'b11));
    chk("aw_id", 64'(m_awid), 64'(id));
    chk("aw_addr", 64'(m_awaddr), 64'(a));
    chk("aw_ctl", 64'({m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos,
                       m_awregion}), 64'(f));
    tick();
    s_awvalid = 0; m_awready = 0;
    wq.push_back(id);
    chk("wr_outstanding", 64'(wro), 64'(wq.size()));
  endtask

  task automatic pass_w(input logic last);
    logic [DW-1:0] d; logic [SW-1:0] st;
    d = $urandom; st = SW'($urandom);
    s_wdata = d; s_wstrb = st; s_wlast = last; s_wvalid = 1; m_wready = 1; #1;
    chk("w_handshake", 64'({m_wvalid, s_wready}), 64'(2'b11));
    chk("w_data", 64'({m_wdata, m_wstrb, m_wlast}), 64'({d, st, last}));
    tick();
    s_wvalid = 0; m_wready = 0; s_wlast = 0;
  endtask

  task automatic role_rburst();
    rd_t t; logic [DW-1:0] d;
    t = rq[0];
    for (int b = 0; b <= int'(t.len); b++) begin
      d = $urandom;
      m_rid = t.id; m_rdata = d; m_rresp = 2'b00; m_rlast = (b == int'(t.len));
      m_rvalid = 1; s_rready = 1; #1;
      chk("r_handshake", 64'({s_rvalid, m_rready}), 64'(2'b11));
      chk("r_id", 64'(s_rid), 64'(t.id));
      chk("r_data", 64'({s_rdata, s_rresp}), 64'({d, 2'b00}));
      chk("r_last", 64'(s_rlast), 64'(b == int'(t.len)));
      tick();
    end
    m_rvalid = 0; s_rready = 0; m_rlast = 0;
    void'(rq.pop_front());
    chk("rd_after_burst", 64'(rdo), 64'(rq.size()));
  endtask

  task automatic role_b();
    m_bid = wq[0]; m_bresp = 2'b00; m_bvalid = 1; s_bready = 1; #1;
    chk("b_handshake", 64'({s_bvalid, m_bready}), 64'(2'b11));
    chk("b_id", 64'({s_bid, s_bresp}), 64'({wq[0], 2'b00}));
    tick();
    m_bvalid = 0; s_bready = 0;
    void'(wq.pop_front());
    chk("wr_after_b", 64'(wro), 64'(wq.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [IW-1:0] id;
    {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos,
     s_awregion, s_awvalid} = '0;
    {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arqos,
     s_arregion, s_arvalid} = '0;
    {s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready, s_rready} = '0;
    {m_awready, m_wready, m_bid, m_bresp, m_bvalid, m_arready} = '0;
    {m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
    req = 0;

    // reset with every valid/ready input asserted
    rstn = 0;
    {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} = '1;
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '1;
    tick(); tick();
    chk("reset_valid_ready", 64'(all_vr), 64'(0));
    chk("reset_status", 64'({ack, terr, rdo, wro}), 64'(0));
    {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} = '0;
    {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
    rstn = 1;
    tick();

    // pass-through: 3 reads (len 3), 2 writes (2 beats)
    for (int i = 0; i < 3; i++) pass_ar(8'd3);
    for (int i = 0; i < 2; i++) pass_aw();
    for (int i = 0; i < 2; i++) begin pass_w(1'b0); pass_w(1'b1); end
    for (int i = 0; i < 3; i++) role_rburst();
    for (int i = 0; i < 2; i++) role_b();
    chk("pass_idle_counts", 64'({rdo, wro}), 64'(0));

    // outstanding cap: 5th AR stalls until a read completes
    for (int i = 0; i < MO; i++) pass_ar(8'd0);
    s_arid = IW'($urandom); s_arlen = 8'd0; s_arvalid = 1; m_arready = 1; #1;
    chk("cap_stall", 64'({s_arready, m_arvalid}), 64'(0));
    tick();
    chk("cap_stall_hold", 64'({s_arready, m_arvalid}), 64'(0));
    m_rid = rq[0].id; m_rlast = 1; m_rvalid = 1; s_rready = 1; #1;
    chk("cap_stall_on_rlast", 64'(s_arready), 64'(0));
    tick();
    void'(rq.pop_front());
    m_rvalid = 0; m_rlast = 0; s_rready = 0; #1;
    chk("cap_release", 64'({rdo, s_arready, m_arvalid}), 64'({3'(rq.size()), 2'b11}));
    id = s_arid;
    tick();
    s_arvalid = 0; m_arready = 0;
    rq.push_back('{id, 8'd0});
    chk("cap_refill", 64'(rdo), 64'(rq.size()));
    for (int i = 0; i < MO; i++) role_rburst();

    // graceful drain with one read (len 7) and one write in flight
    pass_ar(8'd7);
    pass_aw();
    req = 1;
    tick();
    s_arvalid = 1; m_arready = 1; s_awvalid = 1; m_awready = 1; #1;
    chk("drain_blocks_addr", 64'({s_arready, m_arvalid, s_awready, m_awvalid}), 64'(0));
    chk("drain_no_ack", 64'(ack), 64'(0));
    s_arvalid = 0; m_arready = 0; s_awvalid = 0; m_awready = 0;
    pass_w(1'b1);
    role_rburst();
    chk("drain_wait_b", 64'(ack), 64'(0));
    role_b();
    chk("drain_done_ack", 64'({ack, terr}), 64'(2'b10));

    // error responder: AR and AW together, read first
    s_arid = 4'd5; s_arlen = 8'd2; s_arvalid = 1;
    s_awid = 4'd9; s_awvalid = 1; #1;
    chk("err_ar_priority", 64'({s_arready, s_awready}), 64'(2'b10));
    tick();
    s_arvalid = 0; s_rready = 1;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("err_r_beat", 64'({s_rvalid, s_rid, s_rresp, s_rdata, s_rlast}),
          64'({1'b1, 4'd5, 2'b10, 32'd0, b == 2}));
      chk("err_r_isolated", 64'({m_vr, s_awready}), 64'(0));
      tick();
    end
    s_rready = 0; #1;
    chk("err_aw_accept", 64'(s_awready), 64'(1));
    tick();
    s_awvalid = 0; s_wvalid = 1;
    for (int b = 0; b < 4; b++) begin
      s_wdata = $urandom; s_wlast = (b == 3); #1;
      chk("err_w_accept", 64'({s_wready, m_vr, s_bvalid}), 64'({1'b1, 5'd0, 1'b0}));
      tick();
    end
    s_wvalid = 0; s_wlast = 0; #1;
    chk("err_b_resp", 64'({s_bvalid, s_bid, s_bresp, m_vr}), 64'({1'b1, 4'd9, 2'b10, 5'd0}));
    tick();
    chk("err_b_held", 64'({s_bvalid, s_bid}), 64'({1'b1, 4'd9}));
    s_bready = 1;
    tick();
    s_bready = 0;
    chk("err_b_done", 64'({s_bvalid, ack}), 64'(2'b01));

    // release during an error read burst
    id = IW'($urandom);
    s_arid = id; s_arlen = 8'd1; s_arvalid = 1; #1;
    chk("err_ar2_accept", 64'(s_arready), 64'(1));
    tick();
    s_arvalid = 0; req = 0;
    tick();
    chk("release_wait", 64'({ack, s_rvalid, s_rid, s_rlast}), 64'({2'b11, id, 1'b0}));
    s_rready = 1;
    tick();
    chk("release_last_beat", 64'({ack, s_rvalid, s_rlast}), 64'(3'b111));
    tick();
    s_rready = 0;
    id = IW'($urandom);
    s_arid = id; s_arlen = 8'd4; s_arvalid = 1; m_arready = 1; #1;
    chk("release_exit_cycle", 64'({ack, s_arready, m_arvalid}), 64'(3'b100));
    tick();
    chk("release_pass", 64'({ack, m_arvalid, m_arid, s_arready}), 64'({2'b01, id, 1'b1}));
    tick();
    s_arvalid = 0; m_arready = 0;
    rq.push_back('{id, 8'd4});
    chk("release_rd", 64'(rdo), 64'(rq.size()));

    // drain timeout with the role never answering
    req = 1;
    tick();
    chk("timeout_in_drain", 64'(ack), 64'(0));
    n = 0;
    while (ack !== 1'b1 && n < 40) begin tick(); n++; end
    chk("timeout_cycles", 64'(n), 64'(TO));
    rq.delete(); wq.delete();
    chk("timeout_state", 64'({terr, rdo, wro}), 64'({1'b1, 3'd0, 3'd0}));
    req = 0;
    tick();
    chk("timeout_exit", 64'({ack, terr}), 64'(0));

    // one-cycle request pulse still passes through DRAIN
    req = 1;
    tick();
    req = 0;
    s_arvalid = 1; m_arready = 1; s_arid = IW'($urandom); #1;
    chk("pulse_drain_gate", 64'({s_arready, m_arvalid}), 64'(0));
    tick();
    chk("pulse_back_pass", 64'({s_arready, m_arvalid, ack}), 64'(3'b110));
    s_arvalid = 0; m_arready = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
